hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline hazard/stall sequencer for the 5-stage 16-bit CPU; companion to the forwarding unit.
//  Detects load-use hazards forwarding cannot cover, flushes IF/ID on taken branches, freezes the
//  pipe while data memory is busy (with watchdog), and drains/halts the pipe on HLT.
//  Sits in ID; drives PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline register enables/clears.
// PARAMETERS
//  DRAIN_CYCLES  3    cycles after HLT leaves ID until the pipe is empty (EX, MEM, WB)
//  TIMEOUT       255  max consecutive dmem_busy cycles before dmem_timeout; 8-bit counter
// PORTS
//  clk            in   1  clock, rising edge
//  rst            in   1  asynchronous reset, active-high
//  IF_ID_Opcode   in   4  opcode of the instruction in ID
//  IF_ID_Rs       in   4  source register Rs of the instruction in ID
//  IF_ID_Rt       in   4  source register Rt of the instruction in ID
//  ID_EX_Opcode   in   4  opcode of the instruction in EX
//  ID_EX_Rd       in   4  destination register of the instruction in EX
//  branch_taken   in   1  branch in ID resolved taken this cycle
//  dmem_busy      in   1  data memory cannot complete its access this cycle
//  PC_stall       out  1  hold PC
//  IF_ID_stall    out  1  hold IF/ID register
//  IF_ID_flush    out  1  load NOP into IF/ID
//  ID_EX_bubble   out  1  load NOP into ID/EX
//  pipe_freeze    out  1  hold PC, IF/ID, ID/EX and EX/MEM
//  MEM_WB_bubble  out  1  load NOP into MEM/WB
//  halted         out  1  pipe drained after HLT
//  dmem_timeout   out  1  sticky; dmem_busy exceeded TIMEOUT
// BEHAVIOUR
//  Opcodes: LW=4'b1000, SW=4'b1001, B=4'b1100, BR=4'b1101, PCS=4'b1110, HLT=4'b1111.
//  Reset: state=RUN, counters=0; every output 0.
//  Outputs are Mealy, combinational from state and inputs, same cycle; state/counters update on clk.
//  lduse = (ID_EX_Opcode==LW) & (ID_EX_Rd!=0) & (Rs_hit | Rt_hit).
//    Rs_hit = ID_EX_Rd==IF_ID_Rs for any ID opcode except B, PCS, HLT.
//    Rt_hit = ID_EX_Rd==IF_ID_Rt only for ALU ops, opcodes 0xxx.
//    SW data on Rt never stalls; MEM-to-MEM forwarding covers it.
//  Priority, highest first, per cycle:
//    freeze > halt-drain > lduse > branch flush > HLT capture.
//  States:
//   RUN:
//    - dmem_busy: pipe_freeze=1, PC_stall=1, IF_ID_stall=1, MEM_WB_bubble=1; go to FREEZE.
//    - else lduse: PC_stall=1, IF_ID_stall=1, ID_EX_bubble=1 for exactly 1 cycle; stay in RUN.
//      The branch in ID is not flushed during the stall; it re-resolves next cycle.
//    - else branch_taken: IF_ID_flush=1 for 1 cycle.
//    - else IF_ID_Opcode==HLT: HLT passes to EX; go to DRAIN with drain_cnt=0.
//   FREEZE:
//    - Same outputs as RUN+dmem_busy while dmem_busy; busy_cnt increments each frozen cycle.
//    - busy_cnt saturates at TIMEOUT; on reaching TIMEOUT, set dmem_timeout (cleared by rst only).
//    - On !dmem_busy: busy_cnt=0; return to the state held before the freeze (RUN or DRAIN).
//    - That cycle evaluates RUN/DRAIN rules normally.
//   DRAIN:
//    - PC_stall=1, IF_ID_flush=1; no new instructions enter.
//    - drain_cnt increments on non-frozen cycles; dmem_busy here enters FREEZE.
//    - drain_cnt==DRAIN_CYCLES-1 and !dmem_busy: go to HALTED.
//   HALTED:
//    - PC_stall=1, IF_ID_stall=1, halted=1; only rst exits.
//  Async rst at any point, including mid-freeze or mid-drain: immediate return to reset state.
// CONFIGURATION
//  HAZARD_STATS_EN defined: adds outputs stall_cnt[15:0] and flush_cnt[15:0].
//    Both are saturating, cleared by rst.
//    stall_cnt counts lduse stall cycles; flush_cnt counts branch flush cycles.
//  Undefined: those ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  Shared package/header cpu_defs: opcode localparams (LW, SW, B, BR, PCS, HLT) and state encodings
//  RUN/FREEZE/DRAIN/HALTED. Sub-module hazard_detect: combinational lduse equation, reusable by
//  the forwarding checks. FSM, counters and output decode stay in hazard_ctrl.
// TESTING
//  1 ID_EX LW Rd=3; IF_ID ADD Rs=3 -> one cycle of PC_stall=IF_ID_stall=ID_EX_bubble=1, then 0.
//  2 ID_EX LW Rd=3; IF_ID SW Rt=3, Rs=5 -> no stall. Same with Rd=0 and Rs=0 -> no stall.
//  3 branch_taken=1 with no hazard -> IF_ID_flush=1 for 1 cycle.
//    branch_taken=1 with lduse -> stall first, flush the following cycle.
//  4 dmem_busy high 4 cycles in RUN -> pipe_freeze=1 and MEM_WB_bubble=1 for 4 cycles.
//    TIMEOUT=3: dmem_busy 5 cycles -> dmem_timeout=1, stays 1 after busy drops.
//  5 HLT in ID -> DRAIN: PC_stall=IF_ID_flush=1 for 3 cycles, then halted=1.
//    1 dmem_busy cycle in DRAIN -> halted one cycle later.
//  6 rst pulse during DRAIN and during FREEZE -> all outputs 0 at once, state RUN.
//    With HAZARD_STATS_EN: counters return to 0.

Source files
------------

// File: rtl/cpu_defs.sv
// cpu_defs: shared opcode encodings and hazard sequencer state type for the 5-stage 16-bit CPU
package cpu_defs;
    localparam logic [3:0] LW  = 4'b1000;
    localparam logic [3:0] SW  = 4'b1001;
    localparam logic [3:0] B   = 4'b1100;
    localparam logic [3:0] BR  = 4'b1101;
    localparam logic [3:0] PCS = 4'b1110;
    localparam logic [3:0] HLT = 4'b1111;
    typedef enum logic [1:0] {RUN, FREEZE, DRAIN, HALTED} state_t;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: load-use hazard that forwarding cannot cover (SW data on Rt is forwarded MEM-to-MEM)
module hazard_detect
    import cpu_defs::*;
(
    input  logic [3:0] id_op_i,
    input  logic [3:0] id_rs_i,
    input  logic [3:0] id_rt_i,
    input  logic [3:0] ex_op_i,
    input  logic [3:0] ex_rd_i,
    output logic       lduse_o
);
    logic rs_hit, rt_hit;
    assign rs_hit  = (ex_rd_i == id_rs_i) && !(id_op_i == B || id_op_i == PCS || id_op_i == HLT);
    assign rt_hit  = (ex_rd_i == id_rt_i) && !id_op_i[3];
    assign lduse_o = (ex_op_i == LW) && (ex_rd_i != 4'd0) && (rs_hit || rt_hit);
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/freeze/drain sequencer for the pipeline; HAZARD_STATS_EN adds stall/flush counters
module hazard_ctrl
    import cpu_defs::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int TIMEOUT      = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] IF_ID_Opcode,
    input  logic [3:0] IF_ID_Rs,
    input  logic [3:0] IF_ID_Rt,
    input  logic [3:0] ID_EX_Opcode,
    input  logic [3:0] ID_EX_Rd,
    input  logic       branch_taken,
    input  logic       dmem_busy,
    output logic       PC_stall,
    output logic       IF_ID_stall,
    output logic       IF_ID_flush,
    output logic       ID_EX_bubble,
    output logic       pipe_freeze,
    output logic       MEM_WB_bubble,
    output logic       halted,
    output logic       dmem_timeout
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
`endif
);
    state_t     state_q, state_d, ret_q, ret_d, eff;
    logic [7:0] drain_cnt_q, drain_cnt_d, busy_cnt_q, busy_cnt_d;
    logic       timeout_q, timeout_d, lduse, frz;

    hazard_detect u_detect (
        .id_op_i (IF_ID_Opcode),
        .id_rs_i (IF_ID_Rs),
        .id_rt_i (IF_ID_Rt),
        .ex_op_i (ID_EX_Opcode),
        .ex_rd_i (ID_EX_Rd),
        .lduse_o (lduse)
    );

    // FREEZE acts on behalf of the state it interrupted, so rules run on the effective state
    always_comb begin
        eff           = (state_q == FREEZE) ? ret_q : state_q;
        frz           = dmem_busy && eff != HALTED;
        state_d       = eff;
        ret_d         = ret_q;
        drain_cnt_d   = drain_cnt_q;
        busy_cnt_d    = frz ? ((busy_cnt_q == 8'(TIMEOUT)) ? busy_cnt_q : busy_cnt_q + 8'd1) : 8'd0;
        timeout_d     = timeout_q || (frz && busy_cnt_d == 8'(TIMEOUT));
        PC_stall      = 1'b0;
        IF_ID_stall   = 1'b0;
        IF_ID_flush   = 1'b0;
        ID_EX_bubble  = 1'b0;
        pipe_freeze   = 1'b0;
        MEM_WB_bubble = 1'b0;
        halted        = 1'b0;
        if (frz) begin
            pipe_freeze   = 1'b1;
            PC_stall      = 1'b1;
            IF_ID_stall   = 1'b1;
            MEM_WB_bubble = 1'b1;
            state_d       = FREEZE;
            ret_d         = eff;
        end else if (eff == HALTED) begin
            PC_stall    = 1'b1;
            IF_ID_stall = 1'b1;
            halted      = 1'b1;
        end else if (eff == DRAIN) begin
            PC_stall    = 1'b1;
            IF_ID_flush = 1'b1;
            state_d     = (drain_cnt_q == 8'(DRAIN_CYCLES - 1)) ? HALTED : DRAIN;
            drain_cnt_d = drain_cnt_q + 8'd1;
        end else if (lduse) begin
            PC_stall     = 1'b1;
            IF_ID_stall  = 1'b1;
            ID_EX_bubble = 1'b1;
        end else if (branch_taken) begin
            IF_ID_flush = 1'b1;
        end else if (IF_ID_Opcode == HLT) begin
            state_d     = DRAIN;
            drain_cnt_d = 8'd0;
        end
    end

    assign dmem_timeout = timeout_q;

    // state, counters and sticky timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            ret_q       <= RUN;
            drain_cnt_q <= 8'd0;
            busy_cnt_q  <= 8'd0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            drain_cnt_q <= drain_cnt_d;
            busy_cnt_q  <= busy_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt_q, flush_cnt_q;
    // saturating counts of load-use stall cycles and branch flush cycles (RUN-state flushes only)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            if (ID_EX_bubble && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
            if (IF_ID_flush && eff == RUN && flush_cnt_q != 16'hFFFF) flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of stall, flush, freeze/timeout, drain/halt and reset behaviour
module tb_hazard_ctrl;
    logic       clk, rst, branch_taken, dmem_busy;
    logic [3:0] id_op, id_rs, id_rt, ex_op, ex_rd;
    logic       pc_stall, ifid_stall, ifid_flush, idex_bubble, freeze, memwb_bubble, halted, tmo;
    logic [7:0] outs;
    int         vec = 0;
    int         errs = 0;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    localparam logic [7:0] NONE = 8'b0000_0000;
    localparam logic [7:0] LDU  = 8'b1101_0000;
    localparam logic [7:0] FLU  = 8'b0010_0000;
    localparam logic [7:0] FRZ  = 8'b1100_1100;
    localparam logic [7:0] DRN  = 8'b1010_0000;
    localparam logic [7:0] HLTD = 8'b1100_0010;
    localparam logic [7:0] TMO  = 8'b0000_0001;

    hazard_ctrl #(.DRAIN_CYCLES(3), .TIMEOUT(3)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .IF_ID_Opcode  (id_op),
        .IF_ID_Rs      (id_rs),
        .IF_ID_Rt      (id_rt),
        .ID_EX_Opcode  (ex_op),
        .ID_EX_Rd      (ex_rd),
        .branch_taken  (branch_taken),
        .dmem_busy     (dmem_busy),
        .PC_stall      (pc_stall),
        .IF_ID_stall   (ifid_stall),
        .IF_ID_flush   (ifid_flush),
        .ID_EX_bubble  (idex_bubble),
        .pipe_freeze   (freeze),
        .MEM_WB_bubble (memwb_bubble),
        .halted        (halted),
        .dmem_timeout  (tmo)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
`endif
    );

    assign outs = {pc_stall, ifid_stall, ifid_flush, idex_bubble, freeze, memwb_bubble, halted, tmo};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drv(input logic [3:0] op, rs, rt, xop, rd, input logic br, busy);
        id_op = op; id_rs = rs; id_rt = rt; ex_op = xop; ex_rd = rd; branch_taken = br; dmem_busy = busy;
    endtask

    task automatic chk(input string tag, input logic [7:0] exp);
        vec++;
        assert (outs === exp) else begin
            errs++;
            $error("FAIL %s observed=%b expected=%b", tag, outs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [7:0] exp);
        #1 chk(tag, exp);
        @(negedge clk);
    endtask

`ifdef HAZARD_STATS_EN
    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        drv(4'h0, 4'd0, 4'd0, 4'h0, 4'd0, 1'b0, 1'b0);
        #1 chk("reset", NONE);
`ifdef HAZARD_STATS_EN
        chk16("reset_stall_cnt", stall_cnt, 16'd0);
        chk16("reset_flush_cnt", flush_cnt, 16'd0);
`endif
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        // load-use on Rs and on Rt of an ALU op, released once EX holds the bubble
        drv(4'h0, 4'd3, 4'd0, 4'h8, 4'd3, 1'b0, 1'b0); step("lduse_rs", LDU);
        drv(4'h0, 4'd3, 4'd0, 4'h0, 4'd0, 1'b0, 1'b0); step("lduse_release", NONE);
        drv(4'h0, 4'd1, 4'd3, 4'h8, 4'd3, 1'b0, 1'b0); step("lduse_rt", LDU);
        // cases forwarding or register 0 cover, and per-opcode source usage
        drv(4'h9, 4'd5, 4'd3, 4'h8, 4'd3, 1'b0, 1'b0); step("sw_rt_nostall", NONE);
        drv(4'h0, 4'd0, 4'd0, 4'h8, 4'd0, 1'b0, 1'b0); step("rd0_nostall", NONE);
        drv(4'hC, 4'd3, 4'd0, 4'h8, 4'd3, 1'b0, 1'b0); step("b_nostall", NONE);
        drv(4'hD, 4'd3, 4'd0, 4'h8, 4'd3, 1'b0, 1'b0); step("br_rs_stall", LDU);
        drv(4'h8, 4'd3, 4'd3, 4'h8, 4'd3, 1'b0, 1'b0); step("lw_rs_stall", LDU);
        drv(4'h9, 4'd3, 4'd0, 4'h8, 4'd3, 1'b0, 1'b0); step("sw_rs_stall", LDU);
        drv(4'h8, 4'd5, 4'd3, 4'h8, 4'd3, 1'b0, 1'b0); step("lw_rt_nostall", NONE);
        drv(4'hE, 4'd3, 4'd0, 4'h8, 4'd3, 1'b0, 1'b0); step("pcs_nostall", NONE);
        // branch flush, alone and deferred behind a load-use stall
        drv(4'hD, 4'd1, 4'd0, 4'h0, 4'd0, 1'b1, 1'b0); step("branch_flush", FLU);
        drv(4'h0, 4'd1, 4'd0, 4'h0, 4'd0, 1'b0, 1'b0); step("branch_done", NONE);
        drv(4'hD, 4'd3, 4'd0, 4'h8, 4'd3, 1'b1, 1'b0); step("br_lduse_stall", LDU);
        drv(4'hD, 4'd3, 4'd0, 4'h0, 4'd0, 1'b1, 1'b0); step("br_after_stall", FLU);
        // short freeze below the timeout, then a long one that trips it
        drv(4'h0, 4'd1, 4'd2, 4'h0, 4'd0, 1'b0, 1'b1); step("frz1", FRZ);
        step("frz2", FRZ);
        dmem_busy = 1'b0; step("frz_exit", NONE);
        dmem_busy = 1'b1; step("frz_a1", FRZ);
        step("frz_a2", FRZ);
        step("frz_a3", FRZ);
        step("frz_a4_tmo", FRZ | TMO);
        drv(4'h0, 4'd3, 4'd0, 4'h8, 4'd3, 1'b0, 1'b1); step("frz_over_lduse", FRZ | TMO);
        dmem_busy = 1'b0; step("frz_exit_lduse", LDU | TMO);
        drv(4'h0, 4'd1, 4'd2, 4'h0, 4'd0, 1'b0, 1'b0); step("tmo_sticky", TMO);
`ifdef HAZARD_STATS_EN
        chk16("stall_cnt", stall_cnt, 16'd7);
        chk16("flush_cnt", flush_cnt, 16'd2);
`endif
        // reset in the middle of a freeze
        dmem_busy = 1'b1; step("frz_b1", FRZ | TMO);
        step("frz_b2", FRZ | TMO);
        dmem_busy = 1'b0; rst = 1'b1;
        #1 chk("rst_in_freeze", NONE);
`ifdef HAZARD_STATS_EN
        chk16("rst_stall_cnt", stall_cnt, 16'd0);
        chk16("rst_flush_cnt", flush_cnt, 16'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        // HLT drains for three cycles then halts; stalls are ignored once halted
        drv(4'hF, 4'd0, 4'd0, 4'h0, 4'd0, 1'b0, 1'b0); step("hlt_capture", NONE);
        drv(4'h0, 4'd0, 4'd0, 4'h0, 4'd0, 1'b0, 1'b0); step("drain1", DRN);
        step("drain2", DRN);
        step("drain3", DRN);
        step("halted", HLTD);
        drv(4'h0, 4'd3, 4'd0, 4'h8, 4'd3, 1'b1, 1'b0); step("halted_hold", HLTD);
        drv(4'h0, 4'd0, 4'd0, 4'h0, 4'd0, 1'b0, 1'b0); rst = 1'b1;
        #1 chk("rst_halted", NONE);
        @(negedge clk);
        rst = 1'b0;
        // one busy cycle inside the drain postpones the halt by one cycle
        drv(4'hF, 4'd0, 4'd0, 4'h0, 4'd0, 1'b0, 1'b0); step("hlt2_capture", NONE);
        drv(4'h0, 4'd0, 4'd0, 4'h0, 4'd0, 1'b0, 1'b0); step("drain_b1", DRN);
        dmem_busy = 1'b1; step("drain_frz", FRZ);
        dmem_busy = 1'b0; step("drain_b2", DRN);
        step("drain_b3", DRN);
        step("halted_late", HLTD);
        rst = 1'b1;
        #1 chk("rst_halted2", NONE);
        @(negedge clk);
        rst = 1'b0;
        // reset in the middle of a drain
        drv(4'hF, 4'd0, 4'd0, 4'h0, 4'd0, 1'b0, 1'b0); step("hlt3_capture", NONE);
        drv(4'h0, 4'd0, 4'd0, 4'h0, 4'd0, 1'b0, 1'b0); step("drain_c1", DRN);
        rst = 1'b1;
        #1 chk("rst_in_drain", NONE);
        @(negedge clk);
        rst = 1'b0;
        step("run_after_rst", NONE);
        drv(4'hD, 4'd1, 4'd0, 4'h0, 4'd0, 1'b1, 1'b0); step("flush_after_rst", FLU);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
